// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the instruction/data memory-port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic OWNER_I = 1'b0;
  localparam logic OWNER_D = 1'b1;

  localparam int ADDR_W_DEF = 28;
  localparam int DATA_W_DEF = 128;
  localparam int CNT_W_DEF  = 32;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Block read/write port: requester (master) drives read/write/addr/wdata, responder returns rdata/ready.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = mem_arb_pkg::ADDR_W_DEF,
  parameter int DATA_W = mem_arb_pkg::DATA_W_DEF
);
  logic              read;
  logic              write;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              ready;

  modport master (output read, write, addr, wdata, input rdata, ready);
  modport slave  (input read, write, addr, wdata, output rdata, ready);
endinterface

// File: rtl/mem_arb_rr2.sv
// Two-way round-robin picker; on a tie the side that did not win last time is chosen.
module mem_arb_rr2
  import mem_arb_pkg::*;
(
  input  logic clk,
  input  logic proc_reset,
  input  logic req_i,
  input  logic req_d,
  input  logic upd,
  input  logic upd_owner,
  output logic grant_valid,
  output logic grant_owner
);

  logic last_q, last_d;

  always_comb begin
    last_d      = upd ? upd_owner : last_q;
    grant_valid = req_i | req_d;
    if (req_i && req_d) grant_owner = ~last_q;
    else                grant_owner = req_d ? OWNER_D : OWNER_I;
  end

  always_ff @(posedge clk or posedge proc_reset) begin
    if (proc_reset) last_q <= OWNER_I;
    else            last_q <= last_d;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one block memory port between I-side and D-side requesters, one transaction at a time.
// state | meaning: IDLE wait/arbitrate, BUSY strobe held until mem ready, DONE owner ready pulse
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic                 clk,
  input  logic                 proc_reset,
  mem_port_arbiter_if.slave    i_port,
  mem_port_arbiter_if.slave    d_port,
  mem_port_arbiter_if.master   mem_port,
  output logic [CNT_W-1:0]     i_count,
  output logic [CNT_W-1:0]     d_count
);

  state_t            state_q, state_d;
  logic              owner_q, owner_d;
  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              mem_read_q, mem_read_d;
  logic              mem_write_q, mem_write_d;
  logic              i_ready_q, i_ready_d;
  logic              d_ready_q, d_ready_d;
  logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic [CNT_W-1:0]  i_count_q, i_count_d;
  logic [CNT_W-1:0]  d_count_q, d_count_d;

  logic req_i, req_d, rr_upd, grant_valid, grant_owner;

  assign req_i = i_port.read | i_port.write;
  assign req_d = d_port.read | d_port.write;

  mem_arb_rr2 u_rr (
    .clk         (clk),
    .proc_reset  (proc_reset),
    .req_i       (req_i),
    .req_d       (req_d),
    .upd         (rr_upd),
    .upd_owner   (owner_q),
    .grant_valid (grant_valid),
    .grant_owner (grant_owner)
  );

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    wr_d        = wr_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;
    i_ready_d   = 1'b0;
    d_ready_d   = 1'b0;
    i_rdata_d   = i_rdata_q;
    d_rdata_d   = d_rdata_q;
    i_count_d   = i_count_q;
    d_count_d   = d_count_q;
    rr_upd      = 1'b0;

    case (state_q)
      IDLE: begin
        if (grant_valid) begin
          owner_d = grant_owner;
          if (grant_owner == OWNER_D) begin
            wr_d    = d_port.write;
            addr_d  = d_port.addr;
            wdata_d = d_port.wdata;
          end else begin
            wr_d    = i_port.write;
            addr_d  = i_port.addr;
            wdata_d = i_port.wdata;
          end
          mem_read_d  = ~wr_d;
          mem_write_d = wr_d;
          state_d     = BUSY;
        end
      end
      BUSY: begin
        // Only the latched copies drive memory here; live requester inputs are ignored.
        if (mem_port.ready) begin
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
          if (owner_q == OWNER_D) begin
            d_ready_d = 1'b1;
            if (!wr_q) d_rdata_d = mem_port.rdata;
          end else begin
            i_ready_d = 1'b1;
            if (!wr_q) i_rdata_d = mem_port.rdata;
          end
          state_d = DONE;
        end
      end
      DONE: begin
        rr_upd = 1'b1;
        if (owner_q == OWNER_D) d_count_d = d_count_q + 1'b1;
        else                    i_count_d = i_count_q + 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge proc_reset) begin
    if (proc_reset) begin
      state_q     <= IDLE;
      owner_q     <= OWNER_I;
      wr_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      i_ready_q   <= 1'b0;
      d_ready_q   <= 1'b0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
      i_count_q   <= '0;
      d_count_q   <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      wr_q        <= wr_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      i_ready_q   <= i_ready_d;
      d_ready_q   <= d_ready_d;
      i_rdata_q   <= i_rdata_d;
      d_rdata_q   <= d_rdata_d;
      i_count_q   <= i_count_d;
      d_count_q   <= d_count_d;
    end
  end

  assign mem_port.read  = mem_read_q;
  assign mem_port.write = mem_write_q;
  assign mem_port.addr  = addr_q;
  assign mem_port.wdata = wdata_q;
  assign i_port.rdata   = i_rdata_q;
  assign i_port.ready   = i_ready_q;
  assign d_port.rdata   = d_rdata_q;
  assign d_port.ready   = d_ready_q;
  assign i_count        = i_count_q;
  assign d_count        = d_count_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: default instance plus a 2-bit-counter instance for wrap.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic proc_reset = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(28), .DATA_W(128)) ifc_i ();
  mem_port_arbiter_if #(.ADDR_W(28), .DATA_W(128)) ifc_d ();
  mem_port_arbiter_if #(.ADDR_W(28), .DATA_W(128)) ifc_m ();
  mem_port_arbiter_if #(.ADDR_W(28), .DATA_W(128)) ifc2_i ();
  mem_port_arbiter_if #(.ADDR_W(28), .DATA_W(128)) ifc2_d ();
  mem_port_arbiter_if #(.ADDR_W(28), .DATA_W(128)) ifc2_m ();

  logic [31:0] i_count, d_count;
  logic [1:0]  i2_count, d2_count;

  mem_port_arbiter #(.ADDR_W(28), .DATA_W(128), .CNT_W(32)) u_dut (
    .clk        (clk),
    .proc_reset (proc_reset),
    .i_port     (ifc_i),
    .d_port     (ifc_d),
    .mem_port   (ifc_m),
    .i_count    (i_count),
    .d_count    (d_count)
  );

  mem_port_arbiter #(.ADDR_W(28), .DATA_W(128), .CNT_W(2)) u_dut2 (
    .clk        (clk),
    .proc_reset (proc_reset),
    .i_port     (ifc2_i),
    .d_port     (ifc2_d),
    .mem_port   (ifc2_m),
    .i_count    (i2_count),
    .d_count    (d2_count)
  );

  // Memory models: ready pulses in the Nth cycle that the strobe is seen high.
  int rsp_cnt1 = 0;
  int rsp_cnt2 = 0;

  initial begin
    ifc_m.ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (ifc_m.read | ifc_m.write) begin
        rsp_cnt1++;
        if (rsp_cnt1 == 3) begin ifc_m.ready = 1'b1; rsp_cnt1 = 0; end
        else ifc_m.ready = 1'b0;
      end else begin
        ifc_m.ready = 1'b0;
        rsp_cnt1 = 0;
      end
    end
  end

  initial begin
    ifc2_m.ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (ifc2_m.read | ifc2_m.write) begin
        rsp_cnt2++;
        if (rsp_cnt2 == 2) begin ifc2_m.ready = 1'b1; rsp_cnt2 = 0; end
        else ifc2_m.ready = 1'b0;
      end else begin
        ifc2_m.ready = 1'b0;
        rsp_cnt2 = 0;
      end
    end
  end

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic clear_inputs();
    ifc_i.read = 0; ifc_i.write = 0; ifc_i.addr = '0; ifc_i.wdata = '0;
    ifc_d.read = 0; ifc_d.write = 0; ifc_d.addr = '0; ifc_d.wdata = '0;
    ifc2_i.read = 0; ifc2_i.write = 0; ifc2_i.addr = '0; ifc2_i.wdata = '0;
    ifc2_d.read = 0; ifc2_d.write = 0; ifc2_d.addr = '0; ifc2_d.wdata = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    proc_reset = 1'b1;
    tick(); tick();
    proc_reset = 1'b0;
  endtask

  // Waits for a ready pulse on either side of u_dut; reports the first busy-cycle bus view.
  task automatic wait_done(output logic side, output int busy_cyc, output logic wr0,
                           output logic [127:0] wd0, output logic [27:0] ad0);
    bit seen;
    seen = 0; busy_cyc = 0; side = 0; wr0 = 0; wd0 = '0; ad0 = '0;
    for (int n = 0; n < 40; n++) begin
      tick();
      if (ifc_i.ready | ifc_d.ready) begin
        side = ifc_d.ready;
        return;
      end
      if (ifc_m.read | ifc_m.write) begin
        if (!seen) begin
          seen = 1; wr0 = ifc_m.write; wd0 = ifc_m.wdata; ad0 = ifc_m.addr;
        end
        busy_cyc++;
      end
    end
    check_val("done_timeout", 0, 1);
  endtask

  logic         side, wr0;
  int           bcyc;
  logic [127:0] wd0;
  logic [27:0]  ad0;
  logic [127:0] pat40;
  logic [127:0] deadbeef;
  logic [1:0]   exp_seq [5];
  bit           got_rdy;

  initial begin
    pat40    = {32'h0000_0043, 32'h0000_0042, 32'h0000_0041, 32'h0000_0040};
    deadbeef = 128'hDEAD_1111_2222_3333_4444_5555_6666_BEEF;
    exp_seq  = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    clear_inputs();
    ifc_m.rdata  = '0;
    ifc2_m.rdata = '0;

    // Asynchronous reset before the first clock edge
    #1 proc_reset = 1'b1;
    #1;
    check_val("rst_mem_read",  ifc_m.read, 0);
    check_val("rst_mem_write", ifc_m.write, 0);
    check_val("rst_mem_addr",  ifc_m.addr, 0);
    check_val("rst_mem_wdata", ifc_m.wdata, 0);
    check_val("rst_ready",     {ifc_i.ready, ifc_d.ready}, 0);
    check_val("rst_rdata",     ifc_i.rdata | ifc_d.rdata, 0);
    check_val("rst_counts",    {i_count, d_count}, 0);
    tick(); tick();
    proc_reset = 1'b0;

    // Single D read, 3-cycle memory latency
    ifc_m.rdata = pat40;
    ifc_d.read = 1; ifc_d.addr = 28'h000_0010;
    wait_done(side, bcyc, wr0, wd0, ad0);
    check_val("t1_side",      side, 1);
    check_val("t1_i_ready",   ifc_i.ready, 0);
    check_val("t1_busy_cyc",  bcyc, 3);
    check_val("t1_mem_addr",  ad0, 28'h000_0010);
    check_val("t1_is_read",   wr0, 0);
    check_val("t1_d_rdata",   ifc_d.rdata, pat40);
    ifc_d.read = 0;
    tick();
    check_val("t1_ready_pulse", ifc_d.ready, 0);
    tick();
    check_val("t1_d_count", d_count, 1);
    check_val("t1_i_count", i_count, 0);

    // Both sides requesting continuously: D, I, D, I
    do_reset();
    ifc_i.read = 1; ifc_i.addr = 28'h000_0020;
    ifc_d.write = 1; ifc_d.addr = 28'h000_0030; ifc_d.wdata = deadbeef;
    for (int k = 0; k < 4; k++) begin
      wait_done(side, bcyc, wr0, wd0, ad0);
      check_val($sformatf("t2_side%0d", k), side, (k % 2 == 0) ? 1 : 0);
      check_val($sformatf("t2_write%0d", k), wr0, (k % 2 == 0) ? 1 : 0);
      if (k % 2 == 0) check_val($sformatf("t2_wdata%0d", k), wd0, deadbeef);
      else            check_val($sformatf("t2_addr%0d", k), ad0, 28'h000_0020);
    end
    ifc_i.read = 0; ifc_d.write = 0;
    tick(); tick();
    check_val("t2_i_count", i_count, 2);
    check_val("t2_d_count", d_count, 2);

    // I read then I write: write completion leaves i_rdata alone
    ifc_m.rdata = 128'hAAAA;
    ifc_i.read = 1; ifc_i.addr = 28'h000_0005;
    wait_done(side, bcyc, wr0, wd0, ad0);
    check_val("t3_rd_side",  side, 0);
    check_val("t3_i_rdata",  ifc_i.rdata, 128'hAAAA);
    ifc_i.read = 0;
    tick(); tick();
    ifc_m.rdata = 128'hFFFF;
    ifc_i.write = 1; ifc_i.wdata = 128'h1234;
    wait_done(side, bcyc, wr0, wd0, ad0);
    check_val("t3_wr_strobe", wr0, 1);
    check_val("t3_wr_wdata",  wd0, 128'h1234);
    check_val("t3_keep_rdata", ifc_i.rdata, 128'hAAAA);
    ifc_i.write = 0;
    tick(); tick();

    // D request withdrawn and address changed one cycle into BUSY
    ifc_d.read = 1; ifc_d.addr = 28'h0AB_CDEF;
    tick();
    check_val("t4_busy", ifc_m.read, 1);
    ifc_d.read = 0; ifc_d.addr = 28'h123_4567;
    wait_done(side, bcyc, wr0, wd0, ad0);
    check_val("t4_side",      side, 1);
    check_val("t4_held_addr", ad0, 28'h0AB_CDEF);
    tick();
    check_val("t4_one_pulse", ifc_d.ready, 0);
    tick();
    check_val("t4_d_count", d_count, 3);

    // Reset raised mid-BUSY between edges
    do_reset();
    ifc_i.read = 1; ifc_i.addr = 28'h000_0007;
    tick();
    check_val("t5_busy", ifc_m.read, 1);
    #2 proc_reset = 1'b1;
    ifc_i.read = 0;
    #1;
    check_val("t5_strobe_fall", ifc_m.read, 0);
    tick();
    check_val("t5_no_ready", {ifc_i.ready, ifc_d.ready}, 0);
    proc_reset = 1'b0;
    tick();
    check_val("t5_no_ready2", {ifc_i.ready, ifc_d.ready, ifc_m.read}, 0);
    ifc_i.read = 1;
    wait_done(side, bcyc, wr0, wd0, ad0);
    check_val("t5_side", side, 0);
    ifc_i.read = 0;
    tick(); tick();
    check_val("t5_i_count", i_count, 1);

    // 2-bit counter wraps: 1, 2, 3, 0, 1
    for (int k = 0; k < 5; k++) begin
      ifc2_d.read = 1; ifc2_d.addr = 28'h000_0100;
      got_rdy = 0;
      for (int n = 0; n < 40 && !got_rdy; n++) begin
        tick();
        if (ifc2_d.ready) got_rdy = 1;
      end
      if (!got_rdy) check_val("t6_timeout", 0, 1);
      ifc2_d.read = 0;
      tick(); tick();
      check_val($sformatf("t6_d_count%0d", k), d2_count, exp_seq[k]);
    end
    check_val("t6_i_count", i2_count, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Two-requester arbiter that shares the single 128-bit main-memory port between the instruction-side and data-side cache hierarchies (each an L1/L2 pair), in front of the memory model. It presents the same read/write/addr/wdata/rdata/ready protocol upstream on each side and downstream to memory. Arbitration is round-robin and non-preemptive: one memory transaction at a time. Each side has a completed-transaction counter for miss/traffic statistics.

Parameters:
ADDR_W, 28, block address width (word address / 4 words per block)
DATA_W, 128, block data width
CNT_W, 32, width of each transaction counter

Ports:
clk  in  1  system clock, all state on rising edge
proc_reset  in  1  asynchronous, active-high reset
i_read  in  1  I-side block read request, held until i_ready
i_write  in  1  I-side block write request, held until i_ready
i_addr  in  ADDR_W  I-side block address
i_wdata  in  DATA_W  I-side write data
i_rdata  out  DATA_W  I-side read data, valid when i_ready=1
i_ready  out  1  I-side one-cycle completion pulse
d_read, d_write, d_addr, d_wdata, d_rdata, d_ready  same as I-side, for the data side
mem_read  out  1  memory read strobe
mem_write  out  1  memory write strobe
mem_addr  out  ADDR_W  memory block address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data, valid with mem_ready
mem_ready  in  1  memory completion pulse
i_count  out  CNT_W  completed I-side transactions
d_count  out  CNT_W  completed D-side transactions

Behaviour:
- Reset (async, immediate, no clock needed): state=IDLE; mem_read, mem_write, i_ready, d_ready = 0; mem_addr, mem_wdata, i_rdata, d_rdata = 0; counters = 0; last_grant = I, so D wins the first tie.
- All outputs are registered. req_x = x_read | x_write.
- IDLE: with no request, stay in IDLE. With one request, grant it. With both, grant the side not equal to last_grant. On grant, latch owner, op, addr and wdata. Next state BUSY; mem_read or mem_write is asserted from the next cycle.
- Op: write when x_write=1, read otherwise. x_read and x_write both set is treated as a write.
- BUSY: mem_read/mem_write, mem_addr and mem_wdata are held stable from the latches, independent of the live requester inputs. On mem_ready=1: if the op is a read, capture mem_rdata into the owner's rdata register. Next state DONE.
- DONE: mem_read and mem_write = 0. Owner's x_ready = 1 for exactly this cycle. Non-owner ready = 0. last_grant <= owner. Owner's count increments by 1, wrapping from all-ones to 0. Next state IDLE.
- Latency: request sampled at edge n → mem strobe high during cycle n+1. mem_ready at edge m → x_ready high during cycle m+1. Arbitration overhead is 2 cycles per transaction. Strobes are low for at least 2 cycles (DONE, IDLE) between transactions.
- x_rdata holds its value until the next read completion for that side. Write completions leave x_rdata unchanged.
- A request dropped while BUSY does not abort the transaction: it completes and the ready pulse is still issued.
- mem_ready outside BUSY is ignored.
- There is no starvation: a persistently requesting side waits at most one transaction.
- Reset asserted mid-BUSY: strobes fall immediately. The in-flight transaction is abandoned with no ready pulse; requesters are reset by the same signal.

Decomposition:
- Package mem_arb_pkg holds:
  - state enum {IDLE, BUSY, DONE}
  - owner encoding OWNER_I=0, OWNER_D=1
  - default ADDR_W, DATA_W, CNT_W constants
- Sub-module mem_arb_rr2: 2-way round-robin picker with the last_grant flop. Inputs req_i, req_d and an update strobe; outputs grant_valid and grant_owner.
- FSM, latches and counters live in the top module.

Test Plan:
- Reset, then d_read only, d_addr=28'h0000010, memory returns mem_ready 3 cycles after mem_read with rdata=128'h3_2_1_0 (words 0x40..0x43 pattern) → mem_read high 3 cycles; d_ready pulse 1 cycle after mem_ready with d_rdata=that value; i_ready stays 0; d_count=1, i_count=0.
- i_read and d_write asserted together and held continuously after reset → grant order D, I, D, I for four transactions. mem_write carries d_wdata=128'hDEAD...BEEF on the D transactions. Counters end at 2/2.
- I-side write, i_wdata=128'h1234, after a prior I read returned 128'hAAAA → mem_write=1, mem_wdata=128'h1234; i_rdata stays 128'hAAAA.
- d_read dropped and d_addr changed 1 cycle into BUSY → mem_addr stays at the original value; d_ready still pulses once; d_count increments.
- proc_reset raised mid-BUSY between clock edges → mem_read falls before the next edge; no ready pulse. After release, a new i_read is served normally with i_count=1.
- CNT_W=2, five D transactions → d_count sequence 1, 2, 3, 0, 1.
